// File: rtl/layer_compositor.sv
// Two-stage sprite layer compositor: priority layer select with a blinking
// start-screen box background, followed by a timed hit-flash colour effect.
module layer_compositor #(
   parameter int unsigned NUM_LAYERS   = 4,
   parameter int unsigned CW           = 8,
   parameter int unsigned BOX_X0       = 280,
   parameter int unsigned BOX_X1       = 360,
   parameter int unsigned BOX_Y0       = 208,
   parameter int unsigned BOX_Y1       = 272,
   parameter int unsigned BLINK_FRAMES = 32,
   parameter int unsigned FLASH_FRAMES = 8
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic [9:0]                 DrawX,
   input  logic [9:0]                 DrawY,
   input  logic                       pix_valid,
   input  logic                       frame_start,
   input  logic                       start,
   input  logic [NUM_LAYERS-1:0]      layer_on,
   input  logic [NUM_LAYERS-1:0]      layer_en,
   input  logic [NUM_LAYERS*3*CW-1:0] layer_rgb,
   input  logic                       flash_req,
   output logic [CW-1:0]              Red,
   output logic [CW-1:0]              Green,
   output logic [CW-1:0]              Blue,
   output logic                       out_valid
);

   localparam int unsigned BW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
   localparam int unsigned FW = $clog2(FLASH_FRAMES + 1);
   localparam logic [9:0] LP_X0 = 10'(BOX_X0);
   localparam logic [9:0] LP_X1 = 10'(BOX_X1);
   localparam logic [9:0] LP_Y0 = 10'(BOX_Y0);
   localparam logic [9:0] LP_Y1 = 10'(BOX_Y1);

   logic [BW-1:0]   r_blink;
   logic [FW-1:0]   r_flash;
   logic [3*CW-1:0] r_s1_rgb;
   logic            r_s1_valid;
   logic [3*CW-1:0] r_rgb;
   logic            r_out_valid;

   logic            w_in_box;
   logic            w_visible;
   logic [3*CW-1:0] w_bg;
   logic [3*CW-1:0] w_sel;
   logic [3*CW-1:0] w_s2;

   assign w_in_box  = (DrawX >= LP_X0) && (DrawX < LP_X1) && (DrawY >= LP_Y0) && (DrawY < LP_Y1);
   assign w_visible = r_blink < BW'(BLINK_FRAMES / 2);
   assign w_bg      = (start && w_in_box && w_visible) ? '1 : '0;

   // Ascending scan so the highest enabled, hit layer overrides lower ones.
   always_comb begin
      w_sel = w_bg;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         if (layer_on[i] && layer_en[i]) begin
            w_sel = layer_rgb[i*3*CW +: 3*CW];
         end
      end
   end

   always_comb begin
      w_s2 = '0;
      if (r_s1_valid) begin
         if (r_flash != '0) begin
            w_s2 = {{CW{1'b1}}, r_s1_rgb[2*CW-1:CW] >> 1, r_s1_rgb[CW-1:0] >> 1};
         end else begin
            w_s2 = r_s1_rgb;
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_blink <= '0;
      end else if (!start) begin
         r_blink <= '0;
      end else if (frame_start) begin
         r_blink <= (r_blink == BW'(BLINK_FRAMES - 1)) ? '0 : r_blink + 1'b1;
      end
   end

   // A new flash request takes priority over the per-frame decrement.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_flash <= '0;
      end else if (flash_req) begin
         r_flash <= FW'(FLASH_FRAMES);
      end else if (frame_start && (r_flash != '0)) begin
         r_flash <= r_flash - 1'b1;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_s1_rgb    <= '0;
         r_s1_valid  <= 1'b0;
         r_rgb       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_s1_rgb    <= w_sel;
         r_s1_valid  <= pix_valid;
         r_rgb       <= w_s2;
         r_out_valid <= r_s1_valid;
      end
   end

   assign Red       = r_rgb[3*CW-1:2*CW];
   assign Green     = r_rgb[2*CW-1:CW];
   assign Blue      = r_rgb[CW-1:0];
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_layer_compositor.sv
// Directed-vector bench for layer_compositor: priority select, start-box blink,
// hit flash timing, blanking and asynchronous reset behaviour.
module tb_layer_compositor;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [9:0]  DrawX, DrawY;
   logic        pix_valid, frame_start, start, flash_req;
   logic [3:0]  layer_on, layer_en;
   logic [95:0] layer_rgb;
   logic [7:0]  Red, Green, Blue;
   logic        out_valid;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [23:0] L0 = 24'h102030;
   localparam logic [23:0] L1 = 24'h445566;
   localparam logic [23:0] L2 = 24'h804020;
   localparam logic [23:0] L3 = 24'hAABBCC;

   layer_compositor dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .DrawX       (DrawX),
      .DrawY       (DrawY),
      .pix_valid   (pix_valid),
      .frame_start (frame_start),
      .start       (start),
      .layer_on    (layer_on),
      .layer_en    (layer_en),
      .layer_rgb   (layer_rgb),
      .flash_req   (flash_req),
      .Red         (Red),
      .Green       (Green),
      .Blue        (Blue),
      .out_valid   (out_valid)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [24:0] obs, input logic [24:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed {valid,rgb}=%h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic tick2();
      tick();
      tick();
   endtask

   task automatic frames(input int n);
      for (int k = 0; k < n; k++) begin
         frame_start = 1'b1;
         tick();
         frame_start = 1'b0;
      end
   endtask

   task automatic flash_pulse();
      flash_req = 1'b1;
      tick();
      flash_req = 1'b0;
   endtask

   function automatic logic [24:0] pix_out();
      return {out_valid, Red, Green, Blue};
   endfunction

   initial begin
      Reset       = 1'b1;
      DrawX       = '0;
      DrawY       = '0;
      pix_valid   = 1'b0;
      frame_start = 1'b0;
      start       = 1'b0;
      flash_req   = 1'b0;
      layer_on    = '0;
      layer_en    = '0;
      layer_rgb   = {L3, L2, L1, L0};
      #12;
      chk("reset_state", pix_out(), 25'h0);
      @(negedge Clk);
      Reset = 1'b0;

      // Priority select
      layer_on = 4'b1010; layer_en = 4'b1111; pix_valid = 1'b1;
      tick2();
      chk("prio_l3", pix_out(), {1'b1, L3});
      layer_en = 4'b0111;
      tick2();
      chk("prio_l1_masked", pix_out(), {1'b1, L1});
      layer_on = 4'b0000;
      tick2();
      chk("no_layer_bg0", pix_out(), {1'b1, 24'h0});
      layer_on = 4'b0100; layer_en = 4'b1111;
      tick2();
      chk("prio_l2", pix_out(), {1'b1, L2});

      // Start-box edges
      start = 1'b1; layer_on = 4'b0000; DrawX = 10'd280; DrawY = 10'd208;
      tick2();
      chk("box_corner", pix_out(), {1'b1, 24'hFFFFFF});
      DrawX = 10'd360;
      tick2();
      chk("box_x1_out", pix_out(), {1'b1, 24'h0});
      DrawX = 10'd359; DrawY = 10'd271;
      tick2();
      chk("box_far_in", pix_out(), {1'b1, 24'hFFFFFF});
      DrawY = 10'd207;
      tick2();
      chk("box_y0_out", pix_out(), {1'b1, 24'h0});
      DrawX = 10'd280; DrawY = 10'd208; layer_on = 4'b0001;
      tick2();
      chk("sprite_over_box", pix_out(), {1'b1, L0});
      layer_on = 4'b0000;

      // Blink phase
      frames(15);
      tick2();
      chk("blink_15_vis", pix_out(), {1'b1, 24'hFFFFFF});
      frames(1);
      tick2();
      chk("blink_16_hid", pix_out(), {1'b1, 24'h0});
      frames(15);
      tick2();
      chk("blink_31_hid", pix_out(), {1'b1, 24'h0});
      frames(1);
      tick2();
      chk("blink_wrap_vis", pix_out(), {1'b1, 24'hFFFFFF});
      frames(16);
      start = 1'b0;
      tick();
      start = 1'b1;
      tick2();
      chk("blink_held_0", pix_out(), {1'b1, 24'hFFFFFF});
      start = 1'b0;

      // Hit flash duration
      layer_on = 4'b0100;
      flash_pulse();
      tick();
      chk("flash_first", pix_out(), {1'b1, 24'hFF2010});
      frames(7);
      tick2();
      chk("flash_last", pix_out(), {1'b1, 24'hFF2010});
      frames(1);
      tick2();
      chk("flash_done", pix_out(), {1'b1, L2});

      // Load wins over decrement when coincident with frame_start
      frame_start = 1'b1;
      flash_pulse();
      frame_start = 1'b0;
      frames(7);
      tick2();
      chk("flash_coincident", pix_out(), {1'b1, 24'hFF2010});
      frames(1);
      tick2();
      chk("flash_coinc_done", pix_out(), {1'b1, L2});

      // Reload while active
      flash_pulse();
      frames(4);
      flash_pulse();
      frames(7);
      tick2();
      chk("flash_reload", pix_out(), {1'b1, 24'hFF2010});
      frames(1);
      tick2();
      chk("flash_reload_done", pix_out(), {1'b1, L2});

      // Blanking
      pix_valid = 1'b0;
      tick2();
      chk("blank", pix_out(), 25'h0);
      pix_valid = 1'b1;

      // Asynchronous reset during flash and mid-blink
      flash_pulse();
      tick();
      chk("pre_reset_flash", pix_out(), {1'b1, 24'hFF2010});
      #2;
      Reset = 1'b1;
      #1;
      chk("async_reset", pix_out(), 25'h0);
      @(negedge Clk);
      Reset = 1'b0;
      tick();
      chk("first_valid_lat1", pix_out(), 25'h0);
      tick();
      chk("post_reset_noflash", pix_out(), {1'b1, L2});

      start = 1'b1; layer_on = 4'b0000;
      frames(16);
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      tick2();
      chk("post_reset_blink0", pix_out(), {1'b1, 24'hFFFFFF});

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
